// File: rtl/mux4_pkg.sv
// mux4_pkg: shared constants and types for the four-channel round-robin stream mux.
package mux4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
  typedef enum logic {IDLE, LOCKED} state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational four-way round-robin arbiter, priority starting at ptr.
module rr_arbiter4
  import mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] grant,
  output sel_t              idx
);
  sel_t c;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = ptr + sel_t'(k);
      if (!found && req[c]) begin
        found = 1'b1;
        grant[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_stream.sv
// mux4_rr_stream: 4:1 valid/ready stream merge with round-robin grant, optional burst lock,
// and a one-entry registered output tagged with the source channel index.
module mux4_rr_stream
  import mux4_pkg::*;
#(
  parameter int DW = 8,
  parameter int LOCK_BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [4*DW-1:0]  in_data,
  input  logic [3:0]       in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [1:0]       out_sel
);
  state_t state, state_n;
  sel_t ptr, ptr_n, owner, owner_n, arb_idx, gidx;
  logic [NUM_CH-1:0] arb_grant, grant;
  logic can_load, xfer;

  rr_arbiter4 u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign can_load = !out_valid || out_ready;
  assign gidx = (state == LOCKED) ? owner : arb_idx;
  // While locked, only the burst owner may proceed, even if it is idle this cycle.
  assign grant = (state == LOCKED) ? ((NUM_CH'(1) << owner) & in_valid) : arb_grant;
  assign in_ready = rst ? '0 : (grant & {NUM_CH{can_load}});
  assign xfer = |in_ready;

  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    if (xfer) begin
      if (in_last[gidx] || LOCK_BURST == 0) begin
        state_n = IDLE;
        ptr_n = gidx + sel_t'(1);
      end else begin
        state_n = LOCKED;
        owner_n = gidx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sel <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= in_data[gidx*DW +: DW];
        out_last <= in_last[gidx];
        out_sel <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux4_rr_stream.sv
// tb_mux4_rr_stream: directed and random stimulus checked against a cycle-level
// behavioural model of the round-robin merge.
module tb_mux4_rr_stream;
  localparam int LB = 1;
  logic clk, rst;
  logic [3:0] in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  int n_assert = 0, n_fail = 0;
  int m_ptr = 0, m_owner = 0, m_sel = 0;
  bit m_lock = 0, m_valid = 0, m_last = 0;
  logic [7:0] m_data = 0;

  mux4_rr_stream #(.DW(8), .LOCK_BURST(LB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_sel(out_sel)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_sel = 0; m_lock = 0; m_valid = 0; m_last = 0; m_data = 0;
  endtask

  function automatic int pick(input logic [3:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic r);
    int g;
    logic [3:0] er;
    in_valid = v; in_last = l; in_data = d; out_ready = r;
    #1;
    g = pick(v);
    er = (g >= 0 && (!m_valid || r)) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (er != 0) begin
      m_data = d[g*8 +: 8]; m_last = l[g]; m_sel = g; m_valid = 1;
      if (l[g] || LB == 0) begin m_ptr = (g + 1) % 4; m_lock = 0; end
      else begin m_lock = 1; m_owner = g; end
    end else if (m_valid && r) m_valid = 0;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_last", 32'(out_last), 32'(m_last));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rot [5];
    rot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1; in_valid = 4'hF; in_last = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    rst = 0; model_reset();
    // Fair rotation across all four channels
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, 4'hF, 32'hA3A2A1A0, 1);
      chk("rot_sel", 32'(out_sel), 32'(rot[i]));
      chk("rot_data", 32'(out_data), 32'hA0 + 32'(rot[i]));
    end
    // Pointer: after ch2, ch3 beats ch0
    cyc(4'b0100, 4'hF, 32'hA3A2A1A0, 1);
    chk("ptr_sel2", 32'(out_sel), 2);
    cyc(4'b1001, 4'hF, 32'hA3A2A1A0, 1);
    chk("ptr_sel3", 32'(out_sel), 3);
    cyc(4'b1001, 4'hF, 32'hA3A2A1A0, 1);
    chk("ptr_sel0", 32'(out_sel), 0);
    // Burst lock: ch1 three beats while ch0 waits
    cyc(4'b0011, 4'b0000, 32'h00001100, 1);
    chk("burst_sel_a", 32'(out_sel), 1);
    cyc(4'b0011, 4'b0000, 32'h00001200, 1);
    chk("burst_sel_b", 32'(out_sel), 1);
    chk("burst_ch0_blocked", 32'(in_ready[0]), 0);
    cyc(4'b0011, 4'b0010, 32'h00001300, 1);
    chk("burst_sel_c", 32'(out_sel), 1);
    chk("burst_last", 32'(out_last), 1);
    cyc(4'b0011, 4'b0011, 32'h00001301, 1);
    chk("burst_sel_d", 32'(out_sel), 0);
    // Backpressure with 8'h55 pending
    cyc(4'b0010, 4'b0010, 32'h00005500, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, 4'hF, $urandom, 0);
      chk("bp_data", 32'(out_data), 32'h55);
      chk("bp_ready", 32'(in_ready), 0);
    end
    for (int i = 0; i < 4; i++) cyc(4'hF, 4'hF, $urandom, 1);
    // Reset mid-burst
    cyc(4'b0100, 4'b0000, 32'h00770000, 1);
    in_valid = 4'b0101; rst = 1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    #1 rst = 0; model_reset();
    #1 chk("post_rst_ready", 32'(in_ready), 32'b0001);
    cyc(4'b0101, 4'b0101, 32'h00770066, 1);
    chk("post_rst_sel", 32'(out_sel), 0);
    // Random traffic
    for (int i = 0; i < 500; i++)
      cyc(4'($urandom), 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mux4_rr_stream.md
# mux4_rr_stream

Four-to-one streaming multiplexer: merges four valid/ready input channels onto one output stream using round-robin arbitration. Optionally holds the grant for the length of a multi-beat burst. Each output beat is tagged with a 2-bit channel index, so a downstream 1:4 demultiplexer can route the beat back to its lane. This block sits at the merge point in front of a shared datapath, where one channel is granted per beat.

## Interface
Parameters:
- DW, 8, data width per channel.
- LOCK_BURST, 1, 1 = hold grant until the beat carrying `in_last` is accepted; 0 = arbitrate every beat.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel valid; bit i = channel i.
- in_ready  output  4  per-channel ready; at most one bit high in any cycle.
- in_data  input  4*DW  channel i occupies bits [i*DW +: DW].
- in_last  input  4  per-channel end-of-burst flag.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DW  registered beat data.
- out_last  output  1  registered copy of the accepted `in_last`.
- out_sel  output  2  index of the source channel; bit1 is the high select bit, bit0 the low.

## Operation
- Transfer rules:
  - An input transfer occurs on channel i when `in_valid[i] && in_ready[i]`.
  - An output transfer occurs when `out_valid && out_ready`.
- Output register: one entry.
  - `can_load = !out_valid || out_ready`.
  - `in_ready[i] = grant[i] && can_load`.
- Arbitration: combinational.
  - A 2-bit pointer `ptr` gives the highest-priority channel.
  - Priority order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - The grant is one-hot or zero.
- FSM states: IDLE, LOCKED.
  - IDLE: grant goes to the first valid channel in pointer order.
    - On transfer with `in_last=1`, or with LOCK_BURST=0: `ptr <= granted+1` (mod 4) and the state stays IDLE.
    - On transfer with `in_last=0` and LOCK_BURST=1: `owner <= granted` and the state moves to LOCKED. `ptr` is unchanged.
  - LOCKED: the grant is forced to `owner` only.
    - Other channels' `in_ready` stays 0 even when `owner` is not valid.
    - On an owner transfer with `in_last=1`: `ptr <= owner+1` and the state returns to IDLE.
- On each input transfer:
  - `out_data <= selected data`, `out_last <= in_last[granted]`, `out_sel <= granted`, `out_valid <= 1`.
- If an output transfer occurs with no input transfer in the same cycle: `out_valid <= 0`. Data, last and sel hold their values.
- `ptr` and the FSM advance only on input transfers. Toggling `in_valid` without a transfer has no effect.
- Reset values (asynchronous, applied while rst=1):
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`.
  - `ptr=0`, `owner=0`, state = IDLE.
  - `in_ready=0000`.
- Reset mid-burst: the held beat and the lock are discarded. No beat is emitted after reset until a new input transfer.

## Timing
- Latency: an accepted input beat appears on the output in the next cycle.
- Throughput: one beat per cycle while `out_ready=1`. A simultaneous input and output transfer is legal and loses no beat.
- While `out_valid=1 && out_ready=0`: `out_data`, `out_last` and `out_sel` are stable and `in_ready=0000`.
- `in_ready` depends combinationally on `in_valid`, `out_ready`, `ptr` and the state. It has no dependency on `in_data`.
- Switching channels between bursts costs no bubble: a new grant is effective in the cycle after the `in_last` beat is accepted.

## Structure
- Shared package `mux4_pkg`:
  - `NUM_CH=4` and `SEL_W=2`.
  - State enum `{IDLE, LOCKED}` and typedef `sel_t` (2-bit).
- Sub-module `rr_arbiter4`: inputs are a 4-bit request and a 2-bit pointer; the output is a one-hot grant plus its encoded index. It is purely combinational.
- Top level: FSM, `ptr` and `owner` registers, the output register, and the data select.

## Test plan
- Reset: assert rst with all inputs valid. Required response: `out_valid=0`, `in_ready=0000`, `out_sel=0`. Release rst; the first grant goes to ch0.
- Fair rotation: all four channels valid with `in_last=1`, data ch_i=8'hA0+i, `out_ready=1`. Required response: `out_sel` sequence 0,1,2,3,0 with matching data A0,A1,A2,A3,A0; one beat per cycle.
- Pointer: after ch2 is granted, raise ch0 and ch3 together. Required response: ch3 is served first, then ch0.
- Burst lock (LOCK_BURST=1): ch1 sends 3 beats with `in_last` on the third while ch0 is continuously valid. Required response: `out_sel` = 1,1,1,0 and `in_ready[0]=0` throughout the burst. With LOCK_BURST=0 the order is 1,0,1,0…
- Backpressure: hold `out_ready=0` for 5 cycles with beat 8'h55 pending. Required response: `out_data=8'h55` stable and `in_ready=0000`. On release, the subsequent stream has no loss and no duplication.
- Reset mid-burst: ch2 is LOCKED after beat 1 of 3; pulse rst. Required response: `out_valid=0` and state IDLE; ch0 is granted next.
